// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, data and memory-side signals of the two-port memory arbiter
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        sel;
  logic        busy;
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_ack, if_rdata, dm_ack, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata, sel, busy
  );
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_ack, if_rdata, dm_ack, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata, sel, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one fixed-latency memory between fetch and data ports
module mem_arbiter #(
  parameter int MEM_LAT = 2
) (
  input logic         clk,
  input logic         rst,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t     state;
  logic [3:0] cnt;
  logic       last_grant;
  logic       we;
  logic       gnt;
  // last_grant 0 means fetch went last, so contention favours data
  always_comb gnt = (bus.if_req && bus.dm_req) ? ~last_grant : bus.dm_req;
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      last_grant    <= 1'b0;
      we            <= 1'b0;
      bus.if_ack    <= 1'b0;
      bus.dm_ack    <= 1'b0;
      bus.if_rdata  <= '0;
      bus.dm_rdata  <= '0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.sel       <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      bus.mem_en <= 1'b0;
      bus.mem_we <= 1'b0;
      bus.if_ack <= 1'b0;
      bus.dm_ack <= 1'b0;
      case (state)
        IDLE: if (bus.if_req || bus.dm_req) begin
          state         <= ACCESS;
          cnt           <= 4'(MEM_LAT);
          bus.sel       <= gnt;
          bus.busy      <= 1'b1;
          bus.mem_en    <= 1'b1;
          bus.mem_we    <= gnt & bus.dm_we;
          we            <= gnt & bus.dm_we;
          bus.mem_addr  <= gnt ? bus.dm_addr : bus.if_addr;
          bus.mem_wdata <= gnt ? bus.dm_wdata : '0;
        end
        ACCESS: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= RESP;
            if (bus.sel) begin
              bus.dm_ack <= 1'b1;
              if (!we) bus.dm_rdata <= bus.mem_rdata;
            end else begin
              bus.if_ack   <= 1'b1;
              bus.if_rdata <= bus.mem_rdata;
            end
          end
        end
        RESP: begin
          state      <= IDLE;
          bus.busy   <= 1'b0;
          bus.sel    <= 1'b0;
          last_grant <= bus.sel;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL provide parameter MEM_LAT, default 2, meaning memory cycles from issue to valid mem_rdata; legal range 1..15.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port if_req  input  1  instruction-fetch request, level, held until if_ack.
REQ-005 SHALL have port if_addr  input  32  fetch address.
REQ-006 SHALL have port if_ack  output  1  one-cycle fetch completion pulse.
REQ-007 SHALL have port if_rdata  output  32  registered fetch data.
REQ-008 SHALL have port dm_req  input  1  data request, level, held until dm_ack.
REQ-009 SHALL have port dm_we  input  1  1 = store, 0 = load.
REQ-010 SHALL have port dm_addr  input  32  data address.
REQ-011 SHALL have port dm_wdata  input  32  store data.
REQ-012 SHALL have port dm_ack  output  1  one-cycle data completion pulse.
REQ-013 SHALL have port dm_rdata  output  32  registered load data.
REQ-014 SHALL have port mem_en  output  1  memory access strobe.
REQ-015 SHALL have port mem_we  output  1  memory write strobe.
REQ-016 SHALL have port mem_addr  output  32  latched address of granted requester.
REQ-017 SHALL have port mem_wdata  output  32  latched store data.
REQ-018 SHALL have port mem_rdata  input  32  memory read data.
REQ-019 SHALL have port sel  output  1  shared address-mux select; 0 = fetch, 1 = data.
REQ-020 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-021 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-022 SHALL sample requests only in IDLE; requests during ACCESS or RESP are ignored until the next IDLE cycle.
REQ-023 IDLE: only one request high -> grant it; both high -> grant the port not granted last (round-robin via last_grant bit); neither -> stay IDLE.
REQ-024 SHALL, on grant, latch addr, we, wdata and grantee at the IDLE->ACCESS edge and load a 4-bit counter with MEM_LAT.
REQ-025 ACCESS: mem_en and mem_we (if store) high during first ACCESS cycle only; counter decrements each cycle; at counter==1, capture mem_rdata and go to RESP.
REQ-026 RESP: assert grantee's ack for exactly one cycle; update grantee's rdata register on loads and fetches only; stores leave dm_rdata unchanged; next state IDLE; update last_grant.
REQ-027 Latency: request seen in IDLE cycle N -> ack high in cycle N+MEM_LAT+1; minimum back-to-back issue spacing MEM_LAT+2 cycles.
REQ-028 sel SHALL equal the latched grantee throughout ACCESS and RESP, and 0 in IDLE; mem_addr/mem_wdata SHALL hold stable from grant to RESP end.
REQ-029 Requesters drop or change req at the edge ending the ack cycle; a req still high in the following IDLE cycle is a new request.
REQ-030 if_ack and dm_ack SHALL never be high in the same cycle; non-grantee rdata SHALL never change.
REQ-031 Requester inputs changing during ACCESS/RESP SHALL not affect the in-flight access.

Reset
REQ-032 rst high at any edge SHALL force IDLE, counter 0, last_grant = fetch (so first contention grants data), and all outputs 0, including if_rdata and dm_rdata.
REQ-033 rst mid-ACCESS SHALL abort the access with no ack issued; rst has priority over all transitions.

Verification
REQ-034 MEM_LAT=2, if_req only, if_addr=0x00400000, mem_rdata=0x8C080004 -> sel=0, mem_en one cycle, if_ack at cycle 3 with if_rdata=0x8C080004.
REQ-035 After reset, if_req and dm_req both high from cycle 0 -> data granted first (sel=1), fetch granted next; acks alternate, never overlap.
REQ-036 dm_req, dm_we=1, dm_addr=0x10010000, dm_wdata=0xDEADBEEF -> mem_we=1 for one cycle with those values; dm_ack pulses; dm_rdata unchanged.
REQ-037 Both requests held continuously for 8 accesses -> grants strictly alternate data, fetch, data, ...; busy stays high except one IDLE cycle between accesses.
REQ-038 rst asserted in second ACCESS cycle -> next cycle IDLE, all outputs 0, no ack; subsequent request completes normally.
REQ-039 MEM_LAT=1 and MEM_LAT=15 single fetch -> ack exactly MEM_LAT+1 cycles after request sampled.
